// File: rtl/irq_pkg.sv
// Shared types and helpers for the nested interrupt controller: FSM states,
// priority encoder and the width constants used for levels and nesting depth.
package irq_pkg;
    localparam int CH_MAX   = 16;
    localparam int CH_IDX_W = $clog2(CH_MAX);
    localparam int LEVEL_W  = $clog2(CH_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVING = 2'd2
    } irq_state_e;

    typedef struct packed {
        logic                valid;
        logic [CH_IDX_W-1:0] idx;
    } prio_t;

    // Highest set bit wins; ascending scan lets later hits overwrite earlier ones.
    function automatic prio_t prio_enc(input logic [CH_MAX-1:0] vec);
        prio_t r;
        r = '0;
        for (int i = 0; i < CH_MAX; i++) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = CH_IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic int depth_w(input int nest_depth);
        return $clog2(nest_depth + 1);
    endfunction
endpackage

// File: rtl/nested_interrupt_controller_if.sv
// Pipeline-side bundle of the nested interrupt controller: request/eret/PC inputs
// and the entry pulse, vector, EPC and status outputs.
interface nested_interrupt_controller_if #(
    parameter int CHANNELS   = 3,
    parameter int NEST_DEPTH = 4,
    parameter int ADDR_WIDTH = 32
);
    localparam int DEPTH_W = irq_pkg::depth_w(NEST_DEPTH);

    logic                  enable;
    logic [CHANNELS-1:0]   request;
    logic                  interruptEnd;
    logic [ADDR_WIDTH-1:0] savePc;
    logic                  interrupted;
    logic [ADDR_WIDTH-1:0] handlerPc;
    logic [ADDR_WIDTH-1:0] epc;
    logic [CHANNELS-1:0]   interruptOut;
    logic [CHANNELS-1:0]   pending;
    logic [DEPTH_W-1:0]    depth;
    logic                  error;

    modport master (
        output enable, request, interruptEnd, savePc,
        input  interrupted, handlerPc, epc, interruptOut, pending, depth, error
    );

    modport slave (
        input  enable, request, interruptEnd, savePc,
        output interrupted, handlerPc, epc, interruptOut, pending, depth, error
    );
endinterface

// File: rtl/epc_stack.sv
// LIFO of return PCs; one entry per in-service nesting level.
module epc_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count == CW'(i)) mem[i] <= din;
            end
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Slots above count are stale after a pop, so only the live top is exposed.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) top = mem[i];
        end
    end
endmodule

// File: rtl/nested_interrupt_controller.sv
// Fixed-priority, preemptive nested interrupt controller with a hardware EPC stack.
// state   | meaning
// IDLE    | nothing in service, depth = 0
// ENTER   | one-cycle entry pulse, pipeline clear and PC redirect
// SERVING | at least one handler in service, depth > 0
module nested_interrupt_controller #(
    parameter int                    CHANNELS      = 3,
    parameter int                    NEST_DEPTH    = 4,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE   = 32'h0000_0100,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_STRIDE = 32'h0000_0040
) (
    input logic                          clock,
    input logic                          reset,
    nested_interrupt_controller_if.slave bus
);
    import irq_pkg::*;

    localparam int DEPTH_W = depth_w(NEST_DEPTH);

    logic [CHANNELS-1:0]   sync1, sync2, sync3, rise;
    logic [CHANNELS-1:0]   pending_q, in_service_q, eligible, take_mask, ret_mask;
    logic [ADDR_WIDTH-1:0] handler_q;
    logic                  error_q;
    irq_state_e            state_q, state_d;
    prio_t                 cand, top_svc;
    logic [LEVEL_W-1:0]    level;
    logic                  take, ret, stack_full, stack_empty;
    logic [DEPTH_W-1:0]    count;

    assign rise    = sync2 & ~sync3;
    assign top_svc = prio_enc(CH_MAX'(in_service_q));
    assign level   = top_svc.valid ? LEVEL_W'(top_svc.idx) + LEVEL_W'(1) : '0;

    // Only channels strictly above the current level may preempt.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eligible[i] = pending_q[i] && (LEVEL_W'(i) >= level);
        end
    end

    assign cand = prio_enc(CH_MAX'(eligible));
    assign ret  = bus.enable && (state_q == SERVING) && bus.interruptEnd && !stack_empty;
    assign take = bus.enable && (state_q != ENTER) && !bus.interruptEnd
                  && cand.valid && !stack_full;

    always_comb begin
        take_mask = '0;
        ret_mask  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            take_mask[i] = take && (cand.idx == CH_IDX_W'(i));
            ret_mask[i]  = ret && (top_svc.idx == CH_IDX_W'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.enable) begin
            case (state_q)
                IDLE:    if (take) state_d = ENTER;
                ENTER:   state_d = SERVING;
                SERVING: begin
                    if (ret)       state_d = (count == DEPTH_W'(1)) ? IDLE : SERVING;
                    else if (take) state_d = ENTER;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.interrupted = (state_q == ENTER);
    end

    // Synchroniser and pending capture run regardless of enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            sync3        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            handler_q    <= '0;
            error_q      <= 1'b0;
        end else begin
            sync1        <= bus.request;
            sync2        <= sync1;
            sync3        <= sync2;
            pending_q    <= (pending_q | rise) & ~take_mask;
            in_service_q <= (in_service_q | take_mask) & ~ret_mask;
            if (take) handler_q <= VECTOR_BASE + ADDR_WIDTH'(cand.idx) * VECTOR_STRIDE;
            if (bus.enable && (state_q == IDLE) && bus.interruptEnd) error_q <= 1'b1;
        end
    end

    epc_stack #(
        .DEPTH (NEST_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (take),
        .pop   (ret),
        .din   (bus.savePc),
        .top   (bus.epc),
        .count (count),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign bus.handlerPc    = handler_q;
    assign bus.interruptOut = in_service_q;
    assign bus.pending      = pending_q;
    assign bus.depth        = count;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_nested_interrupt_controller.sv
// Scoreboard bench: a queue-based reference model predicts every entry pulse and
// the per-cycle status; a negedge monitor pops and compares.
module tb_nested_interrupt_controller;
    localparam int          CH     = 3;
    localparam int          ND     = 2;
    localparam int          AW     = 32;
    localparam logic [31:0] BASE   = 32'h100;
    localparam logic [31:0] STRIDE = 32'h40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    nested_interrupt_controller_if #(.CHANNELS(CH), .NEST_DEPTH(ND), .ADDR_WIDTH(AW)) bus ();

    nested_interrupt_controller #(
        .CHANNELS(CH), .NEST_DEPTH(ND), .ADDR_WIDTH(AW),
        .VECTOR_BASE(BASE), .VECTOR_STRIDE(STRIDE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-service frames as a stack of (channel, return pc).
    typedef struct { int chan; logic [31:0] pc; } frame_t;
    typedef struct { logic [31:0] handler; logic [31:0] epc; int depth; } entry_t;

    frame_t          m_stack[$];
    entry_t          exp_q[$];
    int              m_mode    = 0;    // 0 idle, 1 entry pulse, 2 serving
    logic [CH-1:0]   m_pending = '0;
    logic [CH-1:0]   h1 = '0, h2 = '0, h3 = '0;   // request sampled 1, 2, 3 edges ago
    logic            m_error   = 1'b0;

    always @(posedge clock) begin : model
        logic [CH-1:0] rise;
        int lvl, cand;
        if (reset) begin
            m_stack.delete();
            m_mode = 0; m_pending = '0; m_error = 1'b0;
            h1 = '0; h2 = '0; h3 = '0;
        end else begin
            rise = h2 & ~h3;
            lvl  = (m_stack.size() == 0) ? 0 : m_stack[$].chan + 1;
            cand = -1;
            for (int i = 0; i < CH; i++) if (m_pending[i] && i >= lvl) cand = i;
            m_pending = m_pending | rise;
            if (bus.enable) begin
                if (m_mode == 1) m_mode = 2;
                else if (bus.interruptEnd) begin
                    if (m_mode == 0) m_error = 1'b1;
                    else begin
                        void'(m_stack.pop_back());
                        if (m_stack.size() == 0) m_mode = 0;
                    end
                end else if (cand >= 0 && m_stack.size() < ND) begin
                    m_stack.push_back('{chan: cand, pc: bus.savePc});
                    m_pending[cand] = 1'b0;
                    m_mode = 1;
                    exp_q.push_back('{handler: BASE + 32'(cand) * STRIDE,
                                      epc: bus.savePc, depth: m_stack.size()});
                end
            end
            h3 = h2; h2 = h1; h1 = bus.request;
        end
    end

    logic prev_int = 1'b0;
    always @(negedge clock) begin : monitor
        logic [CH-1:0] exp_out;
        entry_t e;
        exp_out = '0;
        foreach (m_stack[i]) exp_out[m_stack[i].chan] = 1'b1;
        check("interrupted", 32'(bus.interrupted), 32'(m_mode == 1));
        check("depth", 32'(bus.depth), 32'(m_stack.size()));
        check("interruptOut", 32'(bus.interruptOut), 32'(exp_out));
        check("pending", 32'(bus.pending), 32'(m_pending));
        check("epc", bus.epc, (m_stack.size() == 0) ? 32'h0 : m_stack[$].pc);
        check("error", 32'(bus.error), 32'(m_error));
        if (bus.interrupted === 1'b1 && !prev_int) begin
            if (exp_q.size() == 0) check("unexpected_pulse", 32'(bus.interrupted), 32'h0);
            else begin
                e = exp_q.pop_front();
                check("entry_handlerPc", bus.handlerPc, e.handler);
                check("entry_epc", bus.epc, e.epc);
                check("entry_depth", 32'(bus.depth), 32'(e.depth));
            end
        end
        prev_int = (bus.interrupted === 1'b1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pulse(input string name);
        int n = 0;
        while (bus.interrupted !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({name, "_pulse"}, 32'(bus.interrupted), 32'h1);
    endtask

    task automatic eret();
        bus.interruptEnd = 1'b1;
        tick();
        bus.interruptEnd = 1'b0;
    endtask

    task automatic enter(input int ch, input logic [31:0] pc, input string name);
        bus.savePc      = pc;
        bus.request[ch] = 1'b1;
        wait_pulse(name);
        tick();
        bus.request = '0;
    endtask

    initial begin
        bus.enable = 1'b1; bus.request = '0; bus.interruptEnd = 1'b0; bus.savePc = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("reset_depth", 32'(bus.depth), 0);
        check("reset_out", 32'(bus.interruptOut), 0);
        check("reset_epc", bus.epc, 0);

        // Single entry: pending after edge 2, pulse after edge 3.
        bus.savePc = 32'h40; bus.request[1] = 1'b1;
        tick(); tick();
        check("single_pending_early", 32'(bus.pending), 0);
        tick();
        check("single_pending", 32'(bus.pending), 32'b010);
        tick();
        check("single_pulse", 32'(bus.interrupted), 1);
        check("single_handler", bus.handlerPc, 32'h140);
        tick();
        check("single_out", 32'(bus.interruptOut), 32'b010);
        check("single_depth", 32'(bus.depth), 1);
        check("single_epc", bus.epc, 32'h40);
        bus.request = '0;
        eret();
        check("single_ret_depth", 32'(bus.depth), 0);
        check("single_ret_out", 32'(bus.interruptOut), 0);

        // Preemption by a higher channel.
        enter(0, 32'h10, "pre_ch0");
        bus.savePc = 32'h200; bus.request[2] = 1'b1;
        wait_pulse("pre_ch2");
        check("pre_handler", bus.handlerPc, 32'h180);
        tick(); bus.request = '0;
        check("pre_depth", 32'(bus.depth), 2);
        check("pre_epc", bus.epc, 32'h200);
        eret();
        check("pre_epc_after1", bus.epc, 32'h10);
        eret();
        check("pre_epc_after2", bus.epc, 32'h0);

        // Lower priority waits for the eret.
        enter(2, 32'h300, "np_ch2");
        bus.savePc = 32'h304; bus.request[0] = 1'b1;
        repeat (5) tick();
        check("np_pending", 32'(bus.pending), 32'b001);
        check("np_no_pulse", 32'(bus.interrupted), 0);
        eret();
        check("np_ret_depth", 32'(bus.depth), 0);
        check("np_ret_pulse", 32'(bus.interrupted), 0);
        tick();
        check("np_ch0_pulse", 32'(bus.interrupted), 1);
        check("np_ch0_handler", bus.handlerPc, 32'h100);
        tick(); bus.request = '0;
        eret();

        // Stack full at depth 2.
        enter(0, 32'h20, "full_ch0");
        enter(1, 32'h24, "full_ch1");
        bus.savePc = 32'h28; bus.request[2] = 1'b1;
        repeat (6) tick();
        check("full_pending", 32'(bus.pending), 32'b100);
        check("full_no_pulse", 32'(bus.interrupted), 0);
        eret();
        check("full_ret_depth", 32'(bus.depth), 1);
        tick();
        check("full_ch2_pulse", 32'(bus.interrupted), 1);
        check("full_ch2_depth", 32'(bus.depth), 2);
        check("full_ch2_epc", bus.epc, 32'h28);
        tick(); bus.request = '0;
        eret(); eret();

        // Return and candidate on the same edge: return first.
        enter(0, 32'h50, "sim_ch0");
        bus.savePc = 32'h54; bus.request[2] = 1'b1;
        tick(); tick(); tick();
        check("sim_pending", 32'(bus.pending), 32'b100);
        eret();
        check("sim_ret_depth", 32'(bus.depth), 0);
        check("sim_ret_pulse", 32'(bus.interrupted), 0);
        tick();
        check("sim_ch2_pulse", 32'(bus.interrupted), 1);
        check("sim_ch2_handler", bus.handlerPc, 32'h180);
        tick(); bus.request = '0;
        eret();

        // Eret in idle sets a sticky error.
        eret();
        check("err_set", 32'(bus.error), 1);
        repeat (3) tick();
        check("err_sticky", 32'(bus.error), 1);

        // Stall during the entry pulse.
        bus.savePc = 32'h60; bus.request[1] = 1'b1;
        wait_pulse("stall");
        bus.enable = 1'b0;
        repeat (3) begin
            tick();
            check("stall_hold", 32'(bus.interrupted), 1);
        end
        bus.enable = 1'b1;
        tick();
        check("stall_release", 32'(bus.interrupted), 0);
        bus.request = '0;
        eret();

        // Reset while nested two deep.
        enter(0, 32'h70, "rst_ch0");
        enter(1, 32'h74, "rst_ch1");
        check("rst_pre_depth", 32'(bus.depth), 2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_depth", 32'(bus.depth), 0);
        check("rst_out", 32'(bus.interruptOut), 0);
        check("rst_epc", bus.epc, 0);
        check("rst_error", 32'(bus.error), 0);

        // Randomized traffic against the model.
        repeat (3000) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 7) == 0) bus.request[i] = ~bus.request[i];
            bus.interruptEnd = ($urandom_range(0, 5) == 0);
            bus.enable       = ($urandom_range(0, 9) != 0);
            bus.savePc       = $urandom;
            reset            = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; bus.interruptEnd = 1'b0; bus.request = '0; bus.enable = 1'b1;
        repeat (5) tick();
        @(negedge clock); #1;
        check("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nested_interrupt_controller.md
Name: nested_interrupt_controller

Overview:
- Parametrised successor to the CPU's fixed 3-line interrupt manager: CHANNELS request lines, fixed priority, preemptive nesting up to NEST_DEPTH levels.
- Each accepted interrupt pushes the return PC onto a hardware EPC stack; the EX-stage eret pops it.
- Sits in the global segment and drives the pipeline clears (IF/ID, ID/EX, EX/ME), the PC redirect and the epc forwarding source.

Parameters:
- CHANNELS, 3, number of interrupt request lines (1..16); higher index = higher priority.
- NEST_DEPTH, 4, EPC stack depth = maximum simultaneous in-service levels (1..8).
- ADDR_WIDTH, 32, PC/EPC width.
- VECTOR_BASE, 32'h0000_0100, handler address of channel 0.
- VECTOR_STRIDE, 32'h0000_0040, handler spacing between channels.

Ports:
- clock  in  1  system clock (controlled CPU clock).
- reset  in  1  synchronous, active-high.
- enable  in  1  pipeline enable; 0 freezes the FSM and stack, but the synchroniser and pending capture keep running.
- request  in  CHANNELS  raw level requests (buttons).
- interruptEnd  in  1  eret is in EX (ex_control[7]).
- savePc  in  ADDR_WIDTH  PC to push on entry.
- interrupted  out  1  one-cycle entry pulse; clears the pipeline and redirects the PC.
- handlerPc  out  ADDR_WIDTH  vector of the entered channel; valid while interrupted=1.
- epc  out  ADDR_WIDTH  top-of-stack EPC, combinational; 0 when the stack is empty.
- interruptOut  out  CHANNELS  in-service bitmap (LEDs).
- pending  out  CHANNELS  latched, not-yet-serviced requests.
- depth  out  $clog2(NEST_DEPTH+1)  current nesting level.
- error  out  1  sticky flag: eret arrived with an empty stack.

Behaviour:
- Reset (synchronous): all outputs 0; FSM=IDLE; stack, pending, synchroniser flops and error cleared.
- Input capture: 2-flop synchroniser per channel, then rising-edge detect. A request rising before edge 0 reads as pending=1 after edge 2.
- Pending handling: a pending bit stays set until its channel is entered. A re-assertion while pending is absorbed. A re-assertion while in service sets pending again.
- Current level L: highest index in interruptOut plus 1; L=0 when idle.
- Candidate: highest-index pending bit with index+1 > L.
- FSM states:
  - IDLE: depth=0.
  - ENTER: exactly one cycle, with interrupted=1.
  - SERVING: depth>0.
- Take: in IDLE or SERVING, at an edge with enable=1, a candidate present, depth<NEST_DEPTH and interruptEnd=0. At that edge:
  - push savePc;
  - clear the candidate's pending bit;
  - set its interruptOut bit;
  - depth+1;
  - load handlerPc = VECTOR_BASE + idx*VECTOR_STRIDE (modulo 2^ADDR_WIDTH);
  - go to ENTER.
- ENTER: interrupted=1 for that cycle only. The next edge with enable=1 goes to SERVING. No take and no return are evaluated while in ENTER; interruptEnd is ignored there.
- Return: in SERVING, at an edge with enable=1 and interruptEnd=1:
  - pop;
  - clear the interruptOut bit of the highest in-service channel;
  - depth-1;
  - go to IDLE if depth becomes 0.
  - epc shows the popped value during the cycle before that edge.
- Simultaneous return and candidate: the return wins. The candidate is re-evaluated at the next edge against the new L, so a lower-priority pending request is taken once the higher level exits.
- Stack full: the candidate stays pending and no pulse is issued. It is taken after the next return.
- interruptEnd in IDLE: ignored, error <= 1 (sticky until reset).
- enable=0: FSM, stack, depth, interruptOut and interrupted are held. An ENTER in progress keeps interrupted high until enable returns.
- Reset asserted mid-ENTER or mid-nesting: everything is discarded; the next cycle is IDLE with empty outputs.

Decomposition:
- Shared package irq_pkg holds:
  - FSM state enum {IDLE, ENTER, SERVING};
  - a priority-encoder function (highest set bit, with a valid flag);
  - level width constants derived from CHANNELS and NEST_DEPTH.
- One sub-module, epc_stack: parametrised LIFO with push/pop, top, count and full/empty.
  - Push and pop are mutually exclusive by construction.
  - A pop on empty is a no-op.

Test Plan:
- Single entry (CHANNELS=3):
  - Stimulus: reset, then request[1] rises before edge 0 with savePc=0x40.
  - Required: pending=3'b010 after edge 2; interrupted=1 with handlerPc=0x140 after edge 3; interruptOut=3'b010, depth=1, epc=0x40.
  - Then interruptEnd for one cycle: depth=0, interruptOut=0, FSM=IDLE.
- Preemption:
  - Stimulus: in service on ch0 (savePc=0x10), raise ch2 (savePc=0x200).
  - Required: second pulse with handlerPc=0x180; depth=2; epc=0x200. Eret → epc=0x10. Eret → epc=0.
- No preemption by lower or equal priority:
  - Stimulus: in service on ch2, raise ch0.
  - Required: pending=3'b001 with no pulse. After the eret edge, ch0 is entered one edge later.
- Stack full (NEST_DEPTH=2, CHANNELS=3):
  - Stimulus: nest ch0 then ch1, then raise ch2.
  - Required: ch2 stays pending; interrupted stays 0 until an eret, after which ch2 is entered (depth returns to 2).
- Simultaneous events:
  - Stimulus: interruptEnd and a ch2 candidate at the same edge.
  - Required: pop first (depth-1); entry of ch2 on the following edge.
- Error and stall:
  - Stimulus A: eret in IDLE. Required: error=1 and sticky.
  - Stimulus B: enable=0 during ENTER. Required: interrupted stays 1 until enable=1.
  - Stimulus C: reset during depth=2. Required: all outputs 0 on the next cycle.
